// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial ripple-borrow subtractor, d = ain - bin - bi.
// One full-subtractor cell plus a borrow flip-flop; one bit per clock, LSB first.
// Handshake: a start pulse is accepted when busy is low (IDLE or DONE). done is
// a one-cycle pulse when d/bo become valid; d/bo hold until the next completion.
// Optional macro SUB_OVF_EN adds the ovf output (signed two's-complement overflow).
// dbg_state exposes the FSM state (0=IDLE, 1=RUN, 2=DONE).
module serial_subtractor #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] ain,
  input  logic [W-1:0] bin,
  input  logic         bi,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d,
  output logic         bo,
`ifdef SUB_OVF_EN
  output logic         ovf,
`endif
  output logic [1:0]   dbg_state
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_br;
  logic [W-1:0]    r_res;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_d;
  logic            r_bo;
`ifdef SUB_OVF_EN
  logic            r_ovf;
`endif

  logic            w_a;
  logic            w_b;
  logic            w_diff;
  logic            w_br_nxt;
  logic            w_last;
  logic            w_load;
  logic [W-1:0]    w_res_nxt;

  // Full-subtractor cell on the current operand LSBs.
  always_comb begin
    w_a       = r_a[0];
    w_b       = r_b[0];
    w_diff    = w_a ^ w_b ^ r_br;
    w_br_nxt  = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
    w_res_nxt = {w_diff, r_res[W-1:1]};
    w_last    = (r_cnt == CW'(W - 1));
    w_load    = start && (r_state != S_RUN);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; start during RUN is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand load, serial shift, and result capture at the completion edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_br  <= 1'b0;
      r_res <= '0;
      r_cnt <= '0;
      r_d   <= '0;
      r_bo  <= 1'b0;
`ifdef SUB_OVF_EN
      r_ovf <= 1'b0;
`endif
    end else if (w_load) begin
      r_a   <= ain;
      r_b   <= bin;
      r_br  <= bi;
      r_res <= '0;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_br  <= w_br_nxt;
      r_res <= w_res_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_d  <= w_res_nxt;
        r_bo <= w_br_nxt;
`ifdef SUB_OVF_EN
        // On the last bit r_br is the borrow into the MSB cell.
        r_ovf <= r_br ^ w_br_nxt;
`endif
      end
    end
  end

  // Output decode.
  always_comb begin
    busy      = (r_state == S_RUN);
    done      = (r_state == S_DONE);
    d         = r_d;
    bo        = r_bo;
    dbg_state = r_state;
`ifdef SUB_OVF_EN
    ovf       = r_ovf;
`endif
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor at W=4
// (u_dut) and W=8 (u_dut8). Expected results come from integer arithmetic.
module tb_serial_subtractor;

  localparam int W  = 4;
  localparam int W8 = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start, bi, busy, done, bo;
  logic [W-1:0]  ain, bin, d;
  logic [1:0]    dbg_state;
  logic          start8, bi8, busy8, done8, bo8;
  logic [W8-1:0] ain8, bin8, d8;
  logic [1:0]    dbg_state8;
`ifdef SUB_OVF_EN
  logic          ovf, ovf8;
`endif

  serial_subtractor #(.W(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ain(ain), .bin(bin), .bi(bi),
    .busy(busy), .done(done), .d(d), .bo(bo),
`ifdef SUB_OVF_EN
    .ovf(ovf),
`endif
    .dbg_state(dbg_state)
  );

  serial_subtractor #(.W(W8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .ain(ain8), .bin(bin8), .bi(bi8),
    .busy(busy8), .done(done8), .d(d8), .bo(bo8),
`ifdef SUB_OVF_EN
    .ovf(ovf8),
`endif
    .dbg_state(dbg_state8)
  );

  // ---------------- scoreboard state ----------------
  int n_pass  = 0;
  int n_total = 0;
  int edges   = 0;
  logic [W-1:0] last_d  = '0;
  logic         last_bo = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  // Present operands with start for one edge; edges counts from that edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    ain   = a;
    bin   = b;
    bi    = c;
    start = 1'b1;
    tick();
    edges = 0;
    start = 1'b0;
  endtask

  // Wait (bounded) for done; checks busy/held outputs meanwhile, then results.
  task automatic wait_done(input string tag, input logic [W-1:0] exp_d, input logic exp_bo);
    while (!done && edges < 3 * W) begin
      check({tag, " busy"}, busy, 1'b1);
      check({tag, " d_held"}, d, last_d);
      tick();
    end
    check({tag, " done"}, done, 1'b1);
    check({tag, " latency"}, edges, W);
    check({tag, " busy_off"}, busy, 1'b0);
    check({tag, " d"}, d, exp_d);
    check({tag, " bo"}, bo, exp_bo);
    last_d  = exp_d;
    last_bo = exp_bo;
  endtask

  // One cycle after done: pulse gone, result still held.
  task automatic after_done(input string tag);
    tick();
    check({tag, " done_pulse"}, done, 1'b0);
    check({tag, " d_hold"}, d, last_d);
    check({tag, " bo_hold"}, bo, last_bo);
  endtask

  // Reference model: exact integer subtraction.
  function automatic logic [W:0] ref_sub(input int a, input int b, input int c);
    int r;
    r = a - b - c;
    return (W + 1)'(r);
  endfunction

  function automatic logic ref_ovf(input int a, input int b, input int c, input int w);
    int sa, sb, r;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    r  = sa - sb - c;
    return (r < -(1 << (w - 1))) || (r > (1 << (w - 1)) - 1);
  endfunction

  initial begin
    logic [W:0]  rr;
    logic [W8:0] rr8;
    int a, b, c, n;

    rst_n = 1'b0; start = 1'b0; ain = '0; bin = '0; bi = 1'b0;
    start8 = 1'b0; ain8 = '0; bin8 = '0; bi8 = 1'b0;
    tick(); tick();
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst d", d, 4'h0);
    check("rst bo", bo, 1'b0);
    check("rst state", dbg_state, 2'd0);
`ifdef SUB_OVF_EN
    check("rst ovf", ovf, 1'b0);
`endif
    rst_n = 1'b1;
    tick();

    // Basic directed vectors.
    launch(4'd3, 4'd1, 1'b0);
    check("3-1 state_run", dbg_state, 2'd1);
    wait_done("3-1", 4'b0010, 1'b0);
    check("3-1 state_done", dbg_state, 2'd2);
    after_done("3-1");
    launch(4'd1, 4'd3, 1'b0);  wait_done("1-3", 4'b1110, 1'b1); after_done("1-3");
    launch(4'd5, 4'd13, 1'b1); wait_done("5-13-1", 4'b0111, 1'b1); tick();
    launch(4'd0, 4'd15, 1'b1); wait_done("0-15-1", 4'b0000, 1'b1); tick();
    launch(4'd10, 4'd10, 1'b0); wait_done("10-10", 4'b0000, 1'b0); tick();

    // Start during RUN is ignored; start in the DONE cycle is accepted.
    launch(4'd9, 4'd2, 1'b0);
    ain = 4'd1; bin = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    wait_done("ign", 4'b0111, 1'b0);
    launch(4'd6, 4'd1, 1'b0);
    wait_done("b2b", 4'b0101, 1'b0);
    after_done("b2b");

    // Reset mid-operation.
    launch(4'd12, 4'd3, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort d", d, 4'h0);
    check("abort bo", bo, 1'b0);
    check("abort state", dbg_state, 2'd0);
    last_d = '0; last_bo = 1'b0;
    for (int i = 0; i < W + 1; i++) begin
      tick();
      check("abort no_done", done, 1'b0);
    end
    rst_n = 1'b1;
    tick();
    check("abort idle", done, 1'b0);
    launch(4'd6, 4'd2, 1'b0); wait_done("6-2", 4'b0100, 1'b0); tick();

`ifdef SUB_OVF_EN
    launch(4'd8, 4'd1, 1'b0);  wait_done("ovf 8-1", 4'b0111, 1'b0);
    check("ovf 8-1 ovf", ovf, 1'b1); tick();
    launch(4'd5, 4'd3, 1'b0);  wait_done("ovf 5-3", 4'b0010, 1'b0);
    check("ovf 5-3 ovf", ovf, 1'b0); tick();
    launch(4'd7, 4'd15, 1'b0); wait_done("ovf 7-15", 4'b1000, 1'b1);
    check("ovf 7-15 ovf", ovf, 1'b1); tick();
`endif

    // Random operations at W=4.
    for (int i = 0; i < 200; i++) begin
      a = $urandom_range(0, 15); b = $urandom_range(0, 15); c = $urandom_range(0, 1);
      rr = ref_sub(a, b, c);
      launch(W'(a), W'(b), c[0]);
      wait_done("rnd4", rr[W-1:0], rr[W]);
`ifdef SUB_OVF_EN
      check("rnd4 ovf", ovf, ref_ovf(a, b, c, W));
`endif
      if ($urandom_range(0, 1) == 1) tick();
    end

    // Random operations at W=8.
    for (int i = 0; i < 200; i++) begin
      a = $urandom_range(0, 255); b = $urandom_range(0, 255); c = $urandom_range(0, 1);
      rr8 = (W8 + 1)'(a - b - c);
      ain8 = W8'(a); bin8 = W8'(b); bi8 = c[0]; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      n = 0;
      while (!done8 && n < 3 * W8) begin
        tick();
        n++;
      end
      check("rnd8 latency", n, W8);
      check("rnd8 d", d8, rr8[W8-1:0]);
      check("rnd8 bo", bo8, rr8[W8]);
`ifdef SUB_OVF_EN
      check("rnd8 ovf", ovf8, ref_ovf(a, b, c, W8));
`endif
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
